// File: rtl/hash_output_serializer.sv
// hash_output_serializer: captures the leading digest bits of the Keccak state and streams them as valid/ready words
module hash_output_serializer #(
  parameter int DIGEST_SIZE = 224,
  parameter int WORD_WIDTH  = 64
) (
  input  logic                  CLK,
  input  logic                  A_RST,
  input  logic                  CE,
  input  logic [0:1599]         STATE_IN,
  input  logic                  HASH_VALID,
  output logic                  READY_FOR_HASH,
  output logic [0:WORD_WIDTH-1] DIGEST_DATA,
  output logic                  DIGEST_VALID,
  input  logic                  DIGEST_READY,
  output logic                  DIGEST_LAST,
  output logic                  OVERRUN
);
  localparam int NUM_WORDS = (DIGEST_SIZE + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int CW = NUM_WORDS > 1 ? $clog2(NUM_WORDS) : 1;
  localparam int TW = NUM_WORDS * WORD_WIDTH;
  localparam logic [CW-1:0] LAST_W = CW'(NUM_WORDS - 1);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] wcnt, wcnt_nxt;
  logic [0:TW-1] dig_reg, dig_nxt, cap_word;
  logic ovr_nxt, xfer, fin, cap;
  // Leading DIGEST_SIZE state bits, MSB-first, zero-padded to whole words
  assign cap_word = TW'(({TW'(0), STATE_IN} >> (1600 - DIGEST_SIZE)) << (TW - DIGEST_SIZE));
  assign READY_FOR_HASH = state == IDLE;
  assign DIGEST_VALID = state == SEND;
  assign DIGEST_LAST = DIGEST_VALID && wcnt == LAST_W;
  assign DIGEST_DATA = dig_reg[int'(wcnt) * WORD_WIDTH +: WORD_WIDTH];
  // Next state: a final transfer frees the buffer in the same cycle, so a coincident hash is captured back-to-back
  always_comb begin
    xfer = CE && state == SEND && DIGEST_READY;
    fin = xfer && wcnt == LAST_W;
    cap = CE && HASH_VALID && (state == IDLE || fin);
    state_nxt = cap ? SEND : fin ? IDLE : state;
    wcnt_nxt = (cap || fin) ? '0 : xfer ? wcnt + 1'b1 : wcnt;
    dig_nxt = cap ? cap_word : dig_reg;
    ovr_nxt = CE ? HASH_VALID && !cap : OVERRUN;
  end
  // State register; everything holds when CE is low because the next values do
  always_ff @(posedge CLK or posedge A_RST) begin
    if (A_RST) begin
      state <= IDLE;
      wcnt <= '0;
      dig_reg <= '0;
      OVERRUN <= 1'b0;
    end else begin
      state <= state_nxt;
      wcnt <= wcnt_nxt;
      dig_reg <= dig_nxt;
      OVERRUN <= ovr_nxt;
    end
  end
endmodule

// File: tb/tb_hash_output_serializer.sv
// tb_hash_output_serializer: scoreboard bench for three digest sizes (224, 512, 64) with 64-bit words
module tb_hash_output_serializer;
  typedef struct packed {logic [0:63] d; logic l;} wrd_t;
  logic CLK = 1'b0;
  logic A_RST = 1'b1;
  logic CE = 1'b0;
  logic [0:1599] STATE_IN = '0;
  logic [2:0] hv = '0, rdy = '0, rfh, vld, lst, ovr;
  logic [0:63] dd [3];
  int ds [3] = '{224, 512, 64};
  int checks = 0, failures = 0;
  wrd_t q [3][$];
  logic [0:63] idle_data [3];
  logic [2:0] exp_ovr = '0, pend_acc = '0, pend_ovr = '0;
  logic [0:1599] pend_st = '0;
  int xfers [3] = '{0, 0, 0};
  int ovr_cnt [3] = '{0, 0, 0};
  logic [0:1599] lanes, ff;

  always #5 CLK = ~CLK;

  hash_output_serializer #(.DIGEST_SIZE(224), .WORD_WIDTH(64)) u0 (.CLK(CLK), .A_RST(A_RST), .CE(CE),
    .STATE_IN(STATE_IN), .HASH_VALID(hv[0]), .READY_FOR_HASH(rfh[0]), .DIGEST_DATA(dd[0]),
    .DIGEST_VALID(vld[0]), .DIGEST_READY(rdy[0]), .DIGEST_LAST(lst[0]), .OVERRUN(ovr[0]));
  hash_output_serializer #(.DIGEST_SIZE(512), .WORD_WIDTH(64)) u1 (.CLK(CLK), .A_RST(A_RST), .CE(CE),
    .STATE_IN(STATE_IN), .HASH_VALID(hv[1]), .READY_FOR_HASH(rfh[1]), .DIGEST_DATA(dd[1]),
    .DIGEST_VALID(vld[1]), .DIGEST_READY(rdy[1]), .DIGEST_LAST(lst[1]), .OVERRUN(ovr[1]));
  hash_output_serializer #(.DIGEST_SIZE(64), .WORD_WIDTH(64)) u2 (.CLK(CLK), .A_RST(A_RST), .CE(CE),
    .STATE_IN(STATE_IN), .HASH_VALID(hv[2]), .READY_FOR_HASH(rfh[2]), .DIGEST_DATA(dd[2]),
    .DIGEST_VALID(vld[2]), .DIGEST_READY(rdy[2]), .DIGEST_LAST(lst[2]), .OVERRUN(ovr[2]));

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d got=%h expected=%h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // Word j of a digest of n bits: state bits j*64.. in order, zero beyond the digest length
  function automatic logic [0:63] word(input logic [0:1599] st, input int n, input int j);
    logic [0:63] w;
    for (int i = 0; i < 64; i++) w[i] = (j * 64 + i < n) ? st[j * 64 + i] : 1'b0;
    return w;
  endfunction

  task automatic clear_model();
    for (int k = 0; k < 3; k++) begin
      q[k].delete();
      idle_data[k] = '0;
    end
    exp_ovr = '0;
    pend_acc = '0;
    pend_ovr = '0;
  endtask

  // Apply the decisions made for the edge just passed
  task automatic commit();
    wrd_t w;
    for (int k = 0; k < 3; k++) begin
      if (pend_acc[k]) begin
        for (int j = 0; j < (ds[k] + 63) / 64; j++) begin
          w.d = word(pend_st, ds[k], j);
          w.l = (j == (ds[k] + 63) / 64 - 1);
          q[k].push_back(w);
        end
        idle_data[k] = word(pend_st, ds[k], 0);
      end
      exp_ovr[k] = pend_ovr[k];
    end
  endtask

  // Drive inputs for the coming edge and decide, from the queue occupancy, whether each hash is taken
  task automatic drive(input logic c, input logic [2:0] h, input logic [2:0] r, input logic [0:1599] st);
    int s;
    logic x, a;
    CE = c;
    hv = h;
    rdy = r;
    STATE_IN = st;
    pend_st = st;
    for (int k = 0; k < 3; k++) begin
      s = q[k].size();
      x = c && r[k] && s > 0;
      a = c && h[k] && (s == 0 || (s == 1 && x));
      pend_acc[k] = a;
      pend_ovr[k] = c ? (h[k] && !a) : exp_ovr[k];
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    commit();
  endtask

  task automatic cyc(input logic c, input logic [2:0] h, input logic [2:0] r, input logic [0:1599] st);
    tick();
    drive(c, h, r, st);
  endtask

  task automatic rst_chk();
    for (int k = 0; k < 3; k++) begin
      chk("rst_valid", k, 64'(vld[k]), 64'd0);
      chk("rst_last", k, 64'(lst[k]), 64'd0);
      chk("rst_overrun", k, 64'(ovr[k]), 64'd0);
      chk("rst_ready_for_hash", k, 64'(rfh[k]), 64'd1);
      chk("rst_data", k, dd[k], 64'd0);
    end
  endtask

  // Monitor: compare presented words against the head of each expected queue; pop on transfer
  always @(negedge CLK) begin
    for (int k = 0; k < 3; k++) begin
      chk("valid", k, 64'(vld[k]), 64'(q[k].size() != 0));
      chk("ready_for_hash", k, 64'(rfh[k]), 64'(q[k].size() == 0));
      chk("overrun", k, 64'(ovr[k]), 64'(exp_ovr[k]));
      if (ovr[k] && CE) ovr_cnt[k]++;
      if (q[k].size() != 0) begin
        chk("data", k, dd[k], q[k][0].d);
        chk("last", k, 64'(lst[k]), 64'(q[k][0].l));
        if (CE && rdy[k]) begin
          void'(q[k].pop_front());
          xfers[k]++;
        end
      end else begin
        chk("idle_data", k, dd[k], idle_data[k]);
        chk("idle_last", k, 64'(lst[k]), 64'd0);
      end
    end
  end

  initial begin
    int bx [3];
    int bo;
    logic [2:0] r;
    logic b, found;
    logic [0:1599] rs;
    clear_model();
    for (int l = 0; l < 25; l++) lanes[l * 64 +: 64] = {16{4'(l)}};
    ff = '1;
    #2;
    rst_chk();
    repeat (2) @(negedge CLK);
    #2 A_RST = 1'b0;
    // One hash of the lane pattern, consumer always ready
    bx = xfers;
    cyc(1'b1, 3'b111, 3'b111, lanes);
    repeat (10) cyc(1'b1, 3'b000, 3'b111, lanes);
    chk("single_xfers", 0, 64'(xfers[0] - bx[0]), 64'd4);
    chk("single_xfers", 1, 64'(xfers[1] - bx[1]), 64'd8);
    chk("single_xfers", 2, 64'(xfers[2] - bx[2]), 64'd1);
    // Backpressure with ready pattern 1,0,0,1
    bx = xfers;
    cyc(1'b1, 3'b111, 3'b000, lanes);
    for (int i = 0; i < 24; i++) cyc(1'b1, 3'b000, (i % 4 == 0 || i % 4 == 3) ? 3'b111 : 3'b000, lanes);
    chk("bp_xfers", 0, 64'(xfers[0] - bx[0]), 64'd4);
    chk("bp_xfers", 1, 64'(xfers[1] - bx[1]), 64'd8);
    chk("bp_xfers", 2, 64'(xfers[2] - bx[2]), 64'd1);
    // Back-to-back: second hash on the final-transfer cycle of dut0
    bo = ovr_cnt[0];
    cyc(1'b1, 3'b111, 3'b111, lanes);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      b = q[0].size() == 1;
      drive(1'b1, {2'b00, b}, 3'b111, b ? ff : lanes);
      found = b;
    end
    chk("b2b_reached", 0, 64'(found), 64'd1);
    repeat (8) cyc(1'b1, 3'b000, 3'b111, lanes);
    chk("b2b_no_overrun", 0, 64'(ovr_cnt[0] - bo), 64'd0);
    // Overrun: hash while wcnt=1 and not ready
    bo = ovr_cnt[0];
    cyc(1'b1, 3'b001, 3'b000, lanes);
    cyc(1'b1, 3'b000, 3'b001, lanes);
    cyc(1'b1, 3'b001, 3'b000, ff);
    repeat (6) cyc(1'b1, 3'b000, 3'b001, lanes);
    chk("overrun_pulses", 0, 64'(ovr_cnt[0] - bo), 64'd1);
    // CE gating mid-digest; hashes during CE=0 are ignored
    cyc(1'b1, 3'b111, 3'b111, lanes);
    cyc(1'b1, 3'b000, 3'b111, lanes);
    repeat (3) cyc(1'b0, 3'b111, 3'b111, ff);
    repeat (10) cyc(1'b1, 3'b000, 3'b111, lanes);
    // Asynchronous reset mid-word
    cyc(1'b1, 3'b111, 3'b000, ff);
    cyc(1'b1, 3'b000, 3'b111, ff);
    #3 A_RST = 1'b1;
    clear_model();
    #1 rst_chk();
    @(negedge CLK);
    #2 A_RST = 1'b0;
    drive(1'b0, 3'b000, 3'b000, '0);
    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      for (int w = 0; w < 50; w++) rs[w * 32 +: 32] = $urandom;
      r = 3'($urandom);
      cyc($urandom_range(0, 9) != 0, {$urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
          $urandom_range(0, 4) == 0}, r, rs);
    end
    repeat (20) cyc(1'b1, 3'b000, 3'b111, lanes);
    for (int k = 0; k < 3; k++) chk("drained", k, 64'(vld[k]), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hash_output_serializer.md
# hash_output_serializer

Squeeze-side consumer of the permutation core's state output. On each `HASH_VALID` pulse it captures the leading `DIGEST_SIZE` bits of the 1600-bit Keccak state and streams them out as `WORD_WIDTH`-bit words over a valid/ready handshake. It sits between the permutation core and the host/output bus, so the core never has to hold its state for a slow consumer.

## Interface

Parameters:
- `DIGEST_SIZE`, 224: digest length in bits. Legal range is 1..1600. 224/256/384/512 are used.
- `WORD_WIDTH`, 64: output word width in bits. Must be ≥8.
- Derived: `NUM_WORDS = ceil(DIGEST_SIZE/WORD_WIDTH)`. Counter width is `max(1, clog2(NUM_WORDS))`.

Ports:
- `CLK`, input, 1: the single clock. All flops are rising-edge.
- `A_RST`, input, 1: reset, asynchronous and active-high. It clears every flop.
- `CE`, input, 1: clock enable. When 0, nothing changes and no handshake completes.
- `STATE_IN`, input, [0:1599]: permutation state. Bit 0 is first.
- `HASH_VALID`, input, 1: single-cycle pulse. `STATE_IN` holds the final state in this cycle.
- `READY_FOR_HASH`, output, 1: high when the block is IDLE.
- `DIGEST_DATA`, output, [0:WORD_WIDTH-1]: current output word.
- `DIGEST_VALID`, output, 1: `DIGEST_DATA` is valid.
- `DIGEST_READY`, input, 1: the consumer accepts the word.
- `DIGEST_LAST`, output, 1: the current word is the final word of the digest.
- `OVERRUN`, output, 1: one-cycle pulse. A `HASH_VALID` arrived that could not be captured and was dropped.

## Operation

- Storage: capture register `dig_reg[0:NUM_WORDS*WORD_WIDTH-1]` and word counter `wcnt`.
- States: IDLE and SEND. On reset the state is IDLE, `wcnt`=0 and `dig_reg`=0.
- Capture: `dig_reg[0:DIGEST_SIZE-1] <= STATE_IN[0:DIGEST_SIZE-1]`. Bits from `DIGEST_SIZE` upward load 0. No byte or lane swap is applied; bit order is preserved.
- Word output: `DIGEST_DATA = dig_reg[wcnt*WORD_WIDTH +: WORD_WIDTH]`.
  - In IDLE, `DIGEST_DATA` still shows `dig_reg` word `wcnt`.
  - `DIGEST_VALID` is 0 in IDLE.
- Transfer: a word transfers on an edge where CE=1, `DIGEST_VALID`=1 and `DIGEST_READY`=1.
- IDLE → SEND: on CE=1 with `HASH_VALID`=1. The block captures the state and sets `wcnt`=0.
- SEND, non-final transfer: `wcnt` increments.
- SEND, final transfer (`wcnt`=NUM_WORDS-1):
  - Without `HASH_VALID`: go to IDLE and set `wcnt`=0.
  - With `HASH_VALID` in the same cycle: capture the new state, stay in SEND and set `wcnt`=0. This is back-to-back operation.
- `HASH_VALID` in SEND when no final transfer happens that edge:
  - The new state is not captured.
  - `OVERRUN` is 1 for the next cycle.
  - The digest in progress continues unaffected.
- `DIGEST_LAST = (state==SEND) && (wcnt==NUM_WORDS-1)`.
- Partial last word (`DIGEST_SIZE` not a multiple of `WORD_WIDTH`): the trailing bits are 0.
- `NUM_WORDS`=1: every transfer is a final transfer, and `DIGEST_LAST` is always 1 in SEND.
- `HASH_VALID` with CE=0: ignored entirely, with no capture and no `OVERRUN`.

## Timing

- Reset values:
  - `DIGEST_VALID`=0, `DIGEST_LAST`=0, `OVERRUN`=0.
  - `READY_FOR_HASH`=1.
  - `DIGEST_DATA`=0.
- All outputs are registered or decoded from registers only. There is no combinational path from `HASH_VALID` or `DIGEST_READY` to any output.
- Latency: with `HASH_VALID` sampled at edge t, `DIGEST_VALID`=1 and word 0 appear after edge t. With `DIGEST_READY` held high, the final word is presented in cycle t+NUM_WORDS.
- Throughput: one word per CE-enabled cycle. Back-to-back digests have no bubble cycles.
- Valid/ready rules:
  - `DIGEST_VALID`, `DIGEST_DATA` and `DIGEST_LAST` stay stable until the word transfers.
  - The block never drops `DIGEST_VALID` without a transfer, except on reset.
- Stall: with CE=0 all outputs hold. `OVERRUN` also holds its value.
- Reset mid-digest: `A_RST` immediately clears everything. The partial digest is lost and the block returns to IDLE.

## Test plan

- Reset, then one hash:
  - Stimulus: `DIGEST_SIZE`=224, `STATE_IN` 64-bit lanes = 0x0000000000000000, 0x1111111111111111, 0x2222222222222222, ... and `DIGEST_READY`=1.
  - Response: 4 words in consecutive cycles: 0x0000000000000000, 0x1111111111111111, 0x2222222222222222, then 0x3333333300000000 with `DIGEST_LAST`=1. `READY_FOR_HASH` returns to 1.
- Backpressure:
  - Stimulus: `DIGEST_READY` toggles 1,0,0,1,...
  - Response: each word holds stable while `DIGEST_READY`=0. Exactly 4 transfers occur, in order, with no duplicates.
- Back-to-back:
  - Stimulus: a second `HASH_VALID` (state of all 0xFF bytes) asserted in the final-transfer cycle.
  - Response: the next cycle shows 0xFFFFFFFFFFFFFFFF with `wcnt`=0 and no idle gap. No `OVERRUN`.
- Overrun:
  - Stimulus: `HASH_VALID` while `wcnt`=1 and `DIGEST_READY`=0.
  - Response: `OVERRUN` pulses for 1 cycle. The remaining words come from the first digest.
- CE gating and reset:
  - Stimulus: CE=0 for 3 cycles mid-digest with `DIGEST_READY`=1.
  - Response: no transfers and outputs frozen.
  - Stimulus: `A_RST` asserted mid-word.
  - Response: outputs immediately take their reset values.
- Boundary sizes:
  - Stimulus: `DIGEST_SIZE`=512 with `WORD_WIDTH`=64.
  - Response: 8 full words, with `DIGEST_LAST` only on the 8th.
  - Stimulus: `DIGEST_SIZE`=64.
  - Response: a single word with `DIGEST_LAST`=1.
